piso_serializer_4bit: RTL
=========================

Name: piso_serializer_4bit

Overview:
Parallel-in, serial-out transmitter. It loads a WIDTH-bit word on a LOAD/READY handshake and shifts it out one bit per clock on Dout, MSB first. It is the transmit end for the team's 4-bit serial-in/parallel-out shift register. After WIDTH clocks of valid Dout, that receiver holds B3..B0 = D[3]..D[0]. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word length in bits (>= 2).
IDLE_LEVEL, 1'b0, level driven on Dout when no bit is valid.

Ports:
CLK  input  1  rising-edge clock.
RST  input  1  synchronous, active-low reset (sampled on CLK rising edge).
LOAD  input  1  request to accept D; honoured only when READY=1.
D  input  WIDTH  parallel word; sampled on the edge where LOAD&READY=1.
Dout  output  1  serial data, registered.
FRAME  output  1  registered; 1 while Dout carries a valid bit.
BUSY  output  1  1 while in SHIFT state.
READY  output  1  combinational; 1 when a LOAD would be accepted this cycle.
DONE  output  1  1 during the cycle the last bit (D[0]) is on Dout.

Behaviour:
- Reset: RST=0 at a CLK edge forces the following values.
  - state=IDLE, shift register=0, bit counter=0.
  - Dout=IDLE_LEVEL, FRAME=0, BUSY=0, DONE=0.
  - READY=1 once RST returns high. LOAD is ignored on any edge where RST=0.
- Reset mid-word aborts the transfer immediately. The remaining bits are discarded and no DONE is issued.
- States:
  - IDLE: READY=1, FRAME=0, Dout=IDLE_LEVEL.
  - SHIFT: BUSY=1, FRAME=1.
- IDLE -> SHIFT on an edge with LOAD=1:
  - sreg<=D, cnt<=WIDTH-1.
  - The next cycle shows Dout=D[WIDTH-1]. Latency from accepting edge to first valid bit is 1 clock.
- In SHIFT, each edge shifts sreg left one place (Dout takes the next lower bit) and decrements cnt.
- Last bit: cnt=0 gives DONE=1 and READY=1 in that cycle.
  - LOAD=0 at the next edge: go to IDLE, Dout=IDLE_LEVEL, FRAME=0.
  - LOAD=1 at the next edge: accept the new D, stay in SHIFT, cnt<=WIDTH-1. The new word's MSB follows the old word's LSB with no gap; FRAME stays 1.
- LOAD while READY=0 (SHIFT, cnt>0) is ignored. D is not sampled, the current word completes unchanged, and there is no error flag.
- FRAME is high for exactly WIDTH consecutive cycles per accepted word. DONE is exactly one cycle per word.
- Bit counter width is clog2(WIDTH). It never wraps below 0: cnt=0 always leads to reload or IDLE.
- All outputs are glitch-free registered values except READY and DONE, which are decoded from the state and counter only (no input dependence).
- D may change freely when it is not being sampled.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - default WIDTH=4;
  - IDLE_LEVEL default.
- The 4-bit receiver uses the same WIDTH constant.
- One sub-module is natural: piso_bit_counter (loadable down-counter with zero flag, synchronous active-low reset).
- The shift register and FSM stay in the top module.

Test Plan:
- Reset: hold RST=0 for 2 edges with LOAD=1, D=4'hF -> Dout=0, FRAME=0, BUSY=0, DONE=0; READY=1 after release; no word transmitted.
- Single word: LOAD=1 for one edge with D=4'b1011 -> next 4 cycles Dout=1,0,1,1 with FRAME=1; DONE=1 only on the 4th; then Dout=0, FRAME=0, READY=1.
- Back-to-back: load 4'b1011, then assert LOAD with D=4'b0110 in the DONE cycle -> 8 contiguous FRAME cycles, Dout=1,0,1,1,0,1,1,0; DONE on cycles 4 and 8.
- Busy-ignore: load 4'b1001, then LOAD=1 with D=4'b0111 on cycles 2-3 -> Dout=1,0,0,1 unchanged, READY=0 in those cycles, one DONE, then IDLE.
- Reset mid-word: load 4'b1100, drive RST=0 at the edge ending the 2nd bit -> next cycle FRAME=0, Dout=0, BUSY=0; DONE never asserted.
- Loopback: Dout into the Din of the team's 4-bit serial-in shift register (its reset inactive) on the same CLK, load 4'b1011 -> 4 edges after the first valid bit appears, B3,B2,B1,B0=1,0,1,1.

Source files
------------

// File: rtl/piso_serializer_4bit_pkg.sv
// Shared constants and types for the 4-bit PISO transmitter and its SIPO receiver.
package piso_serializer_4bit_pkg;

    // Word length shared with the matching 4-bit serial-in receiver.
    localparam int   DEF_WIDTH      = 4;
    // Level driven on the serial line when no bit is being sent.
    localparam logic DEF_IDLE_LEVEL = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter width needed to hold WIDTH-1 (at least one bit).
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_4bit_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface piso_serializer_4bit_if #(
    parameter int WIDTH = 4
);
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic             Dout;
    logic             FRAME;
    logic             BUSY;
    logic             READY;
    logic             DONE;

    // Word producer side.
    modport master (
        output LOAD, D,
        input  Dout, FRAME, BUSY, READY, DONE
    );

    // Transmitter side.
    modport slave (
        input  LOAD, D,
        output Dout, FRAME, BUSY, READY, DONE
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module piso_bit_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/piso_serializer_4bit.sv
// Parallel-in serial-out transmitter: accepts a word on LOAD&READY and sends it
// MSB first, one bit per clock, with gapless back-to-back words.
module piso_serializer_4bit
    import piso_serializer_4bit_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic                   CLK,
    input  logic                   RST,
    piso_serializer_4bit_if.slave  bus
);
    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic             dout_q,  dout_d;
    logic             frame_q, frame_d;

    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             ready;
    logic             done;
    logic             accept;
    logic             cnt_dec;

    // READY/DONE depend only on state and count so they never follow inputs.
    assign done    = (state_q == ST_SHIFT) && cnt_zero;
    assign ready   = (state_q == ST_IDLE) || done;
    assign accept  = ready && bus.LOAD;
    assign cnt_dec = (state_q == ST_SHIFT) && !cnt_zero;

    piso_bit_counter #(.CW(CW)) u_cnt (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (accept),
        .load_val (CNT_LAST),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Next-state, shift register and registered serial outputs.
    // sreg holds the current word aligned so that sreg[WIDTH-2] is the next bit.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        frame_d = frame_q;
        if (accept) begin
            state_d = ST_SHIFT;
            sreg_d  = bus.D;
            dout_d  = bus.D[WIDTH-1];
            frame_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (cnt_zero) begin
                state_d = ST_IDLE;
                dout_d  = IDLE_LEVEL;
                frame_d = 1'b0;
            end else begin
                sreg_d  = sreg_q << 1;
                dout_d  = sreg_q[WIDTH-2];
                frame_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            dout_q  <= IDLE_LEVEL;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            frame_q <= frame_d;
        end
    end

    assign bus.Dout  = dout_q;
    assign bus.FRAME = frame_q;
    assign bus.BUSY  = (state_q == ST_SHIFT);
    assign bus.READY = ready;
    assign bus.DONE  = done;

    logic unused_cnt;
    assign unused_cnt = ^cnt;
endmodule
